// File: rtl/mem_bus_pkg.sv
// Shared types and constants for the two-port memory bus arbiter.
package mem_bus_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } arb_state_t;

  localparam int unsigned WE_W   = 2;
  localparam int unsigned SIZE_W = 3;

  // MemWrite encoding from the CPU data side
  localparam logic [WE_W-1:0] WE_NONE = 2'b00;
  localparam logic [WE_W-1:0] WE_BYTE = 2'b01;
  localparam logic [WE_W-1:0] WE_HALF = 2'b10;
  localparam logic [WE_W-1:0] WE_WORD = 2'b11;

  localparam logic [31:0] TIMEOUT_DATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// Requester and memory-side signals of the arbiter; slave = arbiter view, master = environment view.
interface mem_bus_arbiter_if #(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
);
  import mem_bus_pkg::*;

  logic              m0_req,    m1_req;
  logic [AW-1:0]     m0_addr,   m1_addr;
  logic [DW-1:0]     m0_wdata,  m1_wdata;
  logic [WE_W-1:0]   m0_we,     m1_we;
  logic [SIZE_W-1:0] m0_size,   m1_size;
  logic              m0_gnt,    m1_gnt;
  logic              m0_rvalid, m1_rvalid;
  logic [DW-1:0]     m0_rdata,  m1_rdata;

  logic              mem_req;
  logic [AW-1:0]     mem_addr;
  logic [DW-1:0]     mem_wdata;
  logic [WE_W-1:0]   mem_we;
  logic [SIZE_W-1:0] mem_size;
  logic              mem_ready;
  logic              mem_rvalid;
  logic [DW-1:0]     mem_rdata;

  modport slave (
    input  m0_req, m0_addr, m0_wdata, m0_we, m0_size,
    input  m1_req, m1_addr, m1_wdata, m1_we, m1_size,
    output m0_gnt, m0_rvalid, m0_rdata,
    output m1_gnt, m1_rvalid, m1_rdata,
    output mem_req, mem_addr, mem_wdata, mem_we, mem_size,
    input  mem_ready, mem_rvalid, mem_rdata
  );

  modport master (
    output m0_req, m0_addr, m0_wdata, m0_we, m0_size,
    output m1_req, m1_addr, m1_wdata, m1_we, m1_size,
    input  m0_gnt, m0_rvalid, m0_rdata,
    input  m1_gnt, m1_rvalid, m1_rdata,
    input  mem_req, mem_addr, mem_wdata, mem_we, mem_size,
    output mem_ready, mem_rvalid, mem_rdata
  );

endinterface

// File: rtl/mem_bus_arbiter_rr.sv
// Combinational 2-way round-robin pick: a contested request goes to the port that did not win last.
module rr_arbiter2 (
  input  logic [1:0] i_req,
  input  logic       i_rr_last,
  output logic       o_valid_c,
  output logic       o_winner_c
);

  always_comb begin
    o_valid_c  = |i_req;
    o_winner_c = 1'b0;
    case (i_req)
      2'b01:   o_winner_c = 1'b0;
      2'b10:   o_winner_c = 1'b1;
      2'b11:   o_winner_c = ~i_rr_last;
      default: o_winner_c = 1'b0;
    endcase
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter sharing one single-port memory between CPU data (m0) and loader/DMA (m1).
// Define ARB_TIMEOUT_EN to add a read-wait watchdog that returns TIMEOUT_DATA and sets sticky err.
module mem_bus_arbiter
  import mem_bus_pkg::*;
#(
  parameter int unsigned AW             = 32,
  parameter int unsigned DW             = 32,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic                clk,
  input  logic                reset,
  mem_bus_arbiter_if.slave    bus,
  output logic                busy,
  output logic                err
);

  arb_state_t        r_state,   w_state_nxt;
  logic              r_owner,   w_owner_nxt;
  logic              r_rr_last, w_rr_last_nxt;
  logic [AW-1:0]     r_addr,    w_addr_nxt;
  logic [DW-1:0]     r_wdata,   w_wdata_nxt;
  logic [WE_W-1:0]   r_we,      w_we_nxt;
  logic [SIZE_W-1:0] r_size,    w_size_nxt;
  logic [1:0]        r_gnt,     w_gnt_nxt;
  logic [1:0]        r_rvalid,  w_rvalid_nxt;
  logic [DW-1:0]     r_rdata0,  w_rdata0_nxt;
  logic [DW-1:0]     r_rdata1,  w_rdata1_nxt;
  logic              r_mem_req, w_mem_req_nxt;
  logic              r_busy;
  logic              w_pick_valid;
  logic              w_winner;
  logic              w_accept;

`ifdef ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0]  r_to_cnt, w_to_cnt_nxt;
  logic              r_err,    w_err_nxt;
`endif

  rr_arbiter2 u_rr (
    .i_req      ({bus.m1_req, bus.m0_req}),
    .i_rr_last  (r_rr_last),
    .o_valid_c  (w_pick_valid),
    .o_winner_c (w_winner)
  );

  // An issue is accepted only once mem_req is actually presented to the memory
  assign w_accept = r_mem_req & bus.mem_ready;

  // Next-state and next-output logic
  always_comb begin
    w_state_nxt   = r_state;
    w_owner_nxt   = r_owner;
    w_rr_last_nxt = r_rr_last;
    w_addr_nxt    = r_addr;
    w_wdata_nxt   = r_wdata;
    w_we_nxt      = r_we;
    w_size_nxt    = r_size;
    w_gnt_nxt     = 2'b00;
    w_rvalid_nxt  = 2'b00;
    w_rdata0_nxt  = r_rdata0;
    w_rdata1_nxt  = r_rdata1;
    w_mem_req_nxt = 1'b0;
`ifdef ARB_TIMEOUT_EN
    w_to_cnt_nxt  = r_to_cnt;
    w_err_nxt     = r_err;
`endif
    case (r_state)
      IDLE: begin
        if (w_pick_valid) begin
          w_owner_nxt         = w_winner;
          w_rr_last_nxt       = w_winner;
          w_addr_nxt          = w_winner ? bus.m1_addr  : bus.m0_addr;
          w_wdata_nxt         = w_winner ? bus.m1_wdata : bus.m0_wdata;
          w_we_nxt            = w_winner ? bus.m1_we    : bus.m0_we;
          w_size_nxt          = w_winner ? bus.m1_size  : bus.m0_size;
          w_gnt_nxt[w_winner] = 1'b1;
          w_state_nxt         = ISSUE;
        end
      end
      ISSUE: begin
        if (w_accept) begin
          if (r_we != WE_NONE) begin
            w_rvalid_nxt[r_owner] = 1'b1;
            w_state_nxt           = IDLE;
          end else begin
            w_state_nxt = WAIT;
`ifdef ARB_TIMEOUT_EN
            w_to_cnt_nxt = '0;
`endif
          end
        end else begin
          w_mem_req_nxt = 1'b1;
        end
      end
      WAIT: begin
        if (bus.mem_rvalid) begin
          if (r_owner) w_rdata1_nxt = bus.mem_rdata;
          else         w_rdata0_nxt = bus.mem_rdata;
          w_rvalid_nxt[r_owner] = 1'b1;
          w_state_nxt           = IDLE;
        end
`ifdef ARB_TIMEOUT_EN
        // A real response on the expiry cycle wins over the watchdog
        else if (r_to_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          if (r_owner) w_rdata1_nxt = DW'(TIMEOUT_DATA);
          else         w_rdata0_nxt = DW'(TIMEOUT_DATA);
          w_rvalid_nxt[r_owner] = 1'b1;
          w_err_nxt             = 1'b1;
          w_state_nxt           = IDLE;
        end else begin
          w_to_cnt_nxt = r_to_cnt + CNT_W'(1);
        end
`endif
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_owner   <= 1'b0;
      r_rr_last <= 1'b1;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_we      <= WE_NONE;
      r_size    <= '0;
      r_gnt     <= 2'b00;
      r_rvalid  <= 2'b00;
      r_rdata0  <= '0;
      r_rdata1  <= '0;
      r_mem_req <= 1'b0;
      r_busy    <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      r_to_cnt  <= '0;
      r_err     <= 1'b0;
`endif
    end else begin
      r_state   <= w_state_nxt;
      r_owner   <= w_owner_nxt;
      r_rr_last <= w_rr_last_nxt;
      r_addr    <= w_addr_nxt;
      r_wdata   <= w_wdata_nxt;
      r_we      <= w_we_nxt;
      r_size    <= w_size_nxt;
      r_gnt     <= w_gnt_nxt;
      r_rvalid  <= w_rvalid_nxt;
      r_rdata0  <= w_rdata0_nxt;
      r_rdata1  <= w_rdata1_nxt;
      r_mem_req <= w_mem_req_nxt;
      r_busy    <= (w_state_nxt != IDLE);
`ifdef ARB_TIMEOUT_EN
      r_to_cnt  <= w_to_cnt_nxt;
      r_err     <= w_err_nxt;
`endif
    end
  end

  assign bus.m0_gnt    = r_gnt[0];
  assign bus.m1_gnt    = r_gnt[1];
  assign bus.m0_rvalid = r_rvalid[0];
  assign bus.m1_rvalid = r_rvalid[1];
  assign bus.m0_rdata  = r_rdata0;
  assign bus.m1_rdata  = r_rdata1;
  assign bus.mem_req   = r_mem_req;
  assign bus.mem_addr  = r_addr;
  assign bus.mem_wdata = r_wdata;
  assign bus.mem_we    = r_we;
  assign bus.mem_size  = r_size;
  assign busy          = r_busy;

`ifdef ARB_TIMEOUT_EN
  assign err = r_err;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed self-checking bench for mem_bus_arbiter; the timeout section runs only with ARB_TIMEOUT_EN.
module tb_mem_bus_arbiter;
  import mem_bus_pkg::*;

  logic clk;
  logic reset;
  logic busy;
  logic err;
  int   n_total;
  int   n_pass;
  int   n_dual;

  mem_bus_arbiter_if #(.AW(32), .DW(32)) bus ();

  mem_bus_arbiter #(.AW(32), .DW(32), .TIMEOUT_CYCLES(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave),
    .busy  (busy),
    .err   (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Both ports must never see rvalid in the same cycle
  always @(negedge clk) if (bus.m0_rvalid === 1'b1 && bus.m1_rvalid === 1'b1) n_dual++;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %b expected %b", tag, obs, exp);
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic idle_inputs();
    bus.m0_req = 1'b0; bus.m0_addr = '0; bus.m0_wdata = '0; bus.m0_we = WE_NONE; bus.m0_size = '0;
    bus.m1_req = 1'b0; bus.m1_addr = '0; bus.m1_wdata = '0; bus.m1_we = WE_NONE; bus.m1_size = '0;
    bus.mem_ready = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle_inputs();
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    int unsigned order [4];
    order = '{0, 1, 0, 1};
    n_total = 0; n_pass = 0; n_dual = 0;

    // ---- reset state ----
    reset = 1'b1;
    idle_inputs();
    tick();
    tick();
    chk1("rst_gnt0", bus.m0_gnt, 1'b0);
    chk1("rst_gnt1", bus.m1_gnt, 1'b0);
    chk1("rst_rv0", bus.m0_rvalid, 1'b0);
    chk1("rst_rv1", bus.m1_rvalid, 1'b0);
    chk32("rst_rdata0", bus.m0_rdata, 32'h0);
    chk32("rst_rdata1", bus.m1_rdata, 32'h0);
    chk1("rst_mreq", bus.mem_req, 1'b0);
    chk32("rst_maddr", bus.mem_addr, 32'h0);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_err", err, 1'b0);
    reset = 1'b0;

    // ---- contention: word writes from both ports, strict alternation starting with m0 ----
    bus.m0_req = 1'b1; bus.m0_addr = 32'h100; bus.m0_wdata = 32'h1111_0000; bus.m0_we = WE_WORD; bus.m0_size = 3'b010;
    bus.m1_req = 1'b1; bus.m1_addr = 32'h200; bus.m1_wdata = 32'h2222_0000; bus.m1_we = WE_WORD; bus.m1_size = 3'b010;
    bus.mem_ready = 1'b1;
    for (int t = 0; t < 4; t++) begin
      tick();
      chk1("ct_gnt0", bus.m0_gnt, order[t] == 0);
      chk1("ct_gnt1", bus.m1_gnt, order[t] == 1);
      if (t == 3) begin
        bus.m0_req = 1'b0;
        bus.m1_req = 1'b0;
      end
      tick();
      chk1("ct_mreq", bus.mem_req, 1'b1);
      chk32("ct_maddr", bus.mem_addr, (order[t] == 1) ? 32'h200 : 32'h100);
      chk32("ct_mwdata", bus.mem_wdata, (order[t] == 1) ? 32'h2222_0000 : 32'h1111_0000);
      tick();
      chk1("ct_rv0", bus.m0_rvalid, order[t] == 0);
      chk1("ct_rv1", bus.m1_rvalid, order[t] == 1);
    end
    tick();
    chk1("ct_end_gnt0", bus.m0_gnt, 1'b0);
    chk1("ct_end_gnt1", bus.m1_gnt, 1'b0);
    chk1("ct_end_busy", busy, 1'b0);
    chk32("ct_rdata0", bus.m0_rdata, 32'h0);
    chk32("ct_rdata1", bus.m1_rdata, 32'h0);

    // ---- solo m0 read: gnt @1, mem_req @2, rvalid @4 ----
    bus.m0_req = 1'b1; bus.m0_addr = 32'h10; bus.m0_we = WE_NONE; bus.m0_size = 3'b010; bus.m0_wdata = '0;
    tick();
    chk1("rd_gnt0", bus.m0_gnt, 1'b1);
    chk1("rd_gnt1", bus.m1_gnt, 1'b0);
    chk1("rd_mreq_c1", bus.mem_req, 1'b0);
    bus.m0_req = 1'b0;
    tick();
    chk1("rd_mreq_c2", bus.mem_req, 1'b1);
    chk32("rd_maddr", bus.mem_addr, 32'h10);
    chk32("rd_mwe", 32'(bus.mem_we), 32'h0);
    tick();
    chk1("rd_mreq_c3", bus.mem_req, 1'b0);
    chk1("rd_busy_c3", busy, 1'b1);
    chk1("rd_rv0_c3", bus.m0_rvalid, 1'b0);
    bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'hCAFE_F00D;
    tick();
    chk1("rd_rv0_c4", bus.m0_rvalid, 1'b1);
    chk1("rd_rv1_c4", bus.m1_rvalid, 1'b0);
    chk32("rd_rdata0", bus.m0_rdata, 32'hCAFE_F00D);
    bus.mem_rvalid = 1'b0; bus.mem_rdata = '0;
    tick();
    chk1("rd_rv0_c5", bus.m0_rvalid, 1'b0);
    chk1("rd_busy_c5", busy, 1'b0);
    chk32("rd_rdata0_hold", bus.m0_rdata, 32'hCAFE_F00D);

    // ---- memory backpressure on an m1 byte write ----
    bus.m1_req = 1'b1; bus.m1_addr = 32'h300; bus.m1_wdata = 32'h0000_A5A5; bus.m1_we = WE_BYTE; bus.m1_size = 3'b001;
    bus.mem_ready = 1'b0;
    tick();
    chk1("bp_gnt1", bus.m1_gnt, 1'b1);
    chk1("bp_gnt0", bus.m0_gnt, 1'b0);
    bus.m1_req = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk1("bp_mreq", bus.mem_req, 1'b1);
      chk32("bp_maddr", bus.mem_addr, 32'h300);
      chk32("bp_mwdata", bus.mem_wdata, 32'h0000_A5A5);
      chk32("bp_mwe", 32'(bus.mem_we), 32'h1);
      chk32("bp_msize", 32'(bus.mem_size), 32'h1);
      chk1("bp_rv1", bus.m1_rvalid, 1'b0);
    end
    bus.mem_ready = 1'b1;
    tick();
    chk1("bp_rv1_done", bus.m1_rvalid, 1'b1);
    chk1("bp_rv0_done", bus.m0_rvalid, 1'b0);
    chk1("bp_mreq_drop", bus.mem_req, 1'b0);
    chk32("bp_rdata1", bus.m1_rdata, 32'h0);
    tick();
    chk1("bp_busy", busy, 1'b0);

    // ---- reset while in WAIT aborts the m1 read ----
    bus.m1_req = 1'b1; bus.m1_addr = 32'h400; bus.m1_we = WE_NONE; bus.m1_size = 3'b010;
    tick();
    chk1("rw_gnt1", bus.m1_gnt, 1'b1);
    bus.m1_req = 1'b0;
    tick();
    chk1("rw_mreq", bus.mem_req, 1'b1);
    tick();
    chk1("rw_busy_wait", busy, 1'b1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk1("rw_busy_rst", busy, 1'b0);
    chk1("rw_mreq_rst", bus.mem_req, 1'b0);
    chk1("rw_rv1_rst", bus.m1_rvalid, 1'b0);
    bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'hBAD0_BAD0;
    tick();
    chk1("rw_rv0_late", bus.m0_rvalid, 1'b0);
    chk1("rw_rv1_late", bus.m1_rvalid, 1'b0);
    chk32("rw_rdata1", bus.m1_rdata, 32'h0);
    chk1("rw_busy_late", busy, 1'b0);
    bus.mem_rvalid = 1'b0; bus.mem_rdata = '0;
    bus.m0_req = 1'b1; bus.m0_addr = 32'h500; bus.m0_we = WE_WORD; bus.m0_wdata = 32'h5555_5555;
    bus.m1_req = 1'b1; bus.m1_addr = 32'h600; bus.m1_we = WE_WORD; bus.m1_wdata = 32'h6666_6666;
    tick();
    chk1("rw_ct_gnt0", bus.m0_gnt, 1'b1);
    chk1("rw_ct_gnt1", bus.m1_gnt, 1'b0);
    bus.m0_req = 1'b0;
    bus.m1_req = 1'b0;
    tick();
    chk32("rw_ct_maddr", bus.mem_addr, 32'h500);
    tick();
    chk1("rw_ct_rv0", bus.m0_rvalid, 1'b1);
    chk1("rw_ct_rv1", bus.m1_rvalid, 1'b0);
    tick();
    chk1("rw_drop_gnt1", bus.m1_gnt, 1'b0);
    chk1("rw_drop_busy", busy, 1'b0);

    // ---- stray mem_rvalid in IDLE, m1 pulse while busy ----
    bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h1234_5678;
    tick();
    chk1("st_rv0", bus.m0_rvalid, 1'b0);
    chk1("st_rv1", bus.m1_rvalid, 1'b0);
    chk1("st_busy", busy, 1'b0);
    chk32("st_rdata0", bus.m0_rdata, 32'h0);
    bus.mem_rvalid = 1'b0; bus.mem_rdata = '0;
    bus.m0_req = 1'b1; bus.m0_addr = 32'h700; bus.m0_we = WE_NONE;
    tick();
    chk1("st_gnt0", bus.m0_gnt, 1'b1);
    bus.m0_req = 1'b0;
    tick();
    chk1("st_mreq", bus.mem_req, 1'b1);
    bus.m1_req = 1'b1; bus.m1_addr = 32'h800; bus.m1_we = WE_WORD;
    tick();
    bus.m1_req = 1'b0;
    chk1("st_gnt1_a", bus.m1_gnt, 1'b0);
    bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h0BAD_F00D;
    tick();
    chk1("st_rd_rv0", bus.m0_rvalid, 1'b1);
    chk32("st_rd_data", bus.m0_rdata, 32'h0BAD_F00D);
    chk1("st_gnt1_b", bus.m1_gnt, 1'b0);
    bus.mem_rvalid = 1'b0; bus.mem_rdata = '0;
    tick();
    chk1("st_gnt1_c", bus.m1_gnt, 1'b0);
    chk1("st_busy_end", busy, 1'b0);
    tick();
    chk1("st_gnt1_d", bus.m1_gnt, 1'b0);

`ifdef ARB_TIMEOUT_EN
    // ---- read that never returns: watchdog after 8 WAIT cycles ----
    do_reset();
    bus.m0_req = 1'b1; bus.m0_addr = 32'h900; bus.m0_we = WE_NONE;
    bus.mem_ready = 1'b1;
    tick();
    chk1("to_gnt0", bus.m0_gnt, 1'b1);
    bus.m0_req = 1'b0;
    tick();
    chk1("to_mreq", bus.mem_req, 1'b1);
    for (int i = 0; i < 8; i++) begin
      tick();
      chk1("to_rv0_wait", bus.m0_rvalid, 1'b0);
      chk1("to_err_wait", err, 1'b0);
    end
    tick();
    chk1("to_rv0", bus.m0_rvalid, 1'b1);
    chk32("to_rdata0", bus.m0_rdata, 32'hDEAD_BEEF);
    chk1("to_err", err, 1'b1);
    tick();
    chk1("to_rv0_off", bus.m0_rvalid, 1'b0);
    chk1("to_busy", busy, 1'b0);
    chk1("to_err_sticky", err, 1'b1);
    tick();
    chk1("to_err_sticky2", err, 1'b1);
`else
    do_reset();
    chk1("no_to_err", err, 1'b0);
`endif

    chk32("one_rvalid", 32'(n_dual), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares one single-port data memory between two requesters: the CPU data port (m0) and a program-loader/DMA port (m1).
- Round-robin arbitration; one outstanding transaction at a time; registered grant and response.
- Sits between the cpu_usm_v1 data side (write_direction, data_out, MemWrite, SizeLoad, data_in) and the memory macro. The memory side uses a req/ready issue handshake and an rvalid read return.

Parameters:
- AW, 32, address width
- DW, 32, data width
- TIMEOUT_CYCLES, 64, read-wait watchdog limit; used only with ARB_TIMEOUT_EN

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high
- m0_req, m1_req  in  1  request; held with attributes until mN_gnt
- m0_addr, m1_addr  in  AW  byte address
- m0_wdata, m1_wdata  in  DW  write data
- m0_we, m1_we  in  2  write enable, MemWrite encoding; 00 = read
- m0_size, m1_size  in  3  SizeLoad encoding, passed through unchanged
- m0_gnt, m1_gnt  out  1  one-cycle pulse: request latched
- m0_rvalid, m1_rvalid  out  1  one-cycle pulse: transaction complete (read data or write ack)
- m0_rdata, m1_rdata  out  DW  read data, held until that port's next rvalid
- mem_req  out  1  issue request to memory
- mem_addr  out  AW  latched address
- mem_wdata  out  DW  latched write data
- mem_we  out  2  latched write enable
- mem_size  out  3  latched size
- mem_ready  in  1  memory accepts issue this cycle
- mem_rvalid  in  1  read data valid
- mem_rdata  in  DW  read data
- busy  out  1  state != IDLE
- err  out  1  sticky timeout flag; tied 0 without ARB_TIMEOUT_EN

Behaviour:
- Reset:
  - State IDLE.
  - All outputs 0, including rdata registers.
  - rr_last = 1, so m0 wins the first contested arbitration.
  - A reset asserted mid-transaction aborts it: no rvalid, no gnt, mem_req = 0 next cycle.
- States: IDLE, ISSUE, WAIT.
- IDLE:
  - If any mN_req: winner = sole requester. If both request, winner = the port != rr_last.
  - Latch addr/wdata/we/size and owner. Pulse winner's gnt. rr_last <= winner. Go to ISSUE.
  - Requests are sampled only in IDLE.
- ISSUE:
  - mem_req = 1 with latched fields; fields are stable while mem_req = 1.
  - On mem_ready with we != 00: pulse owner rvalid next cycle (rdata unchanged), go to IDLE.
  - On mem_ready with we == 00: go to WAIT. mem_req drops after the accept cycle.
- WAIT:
  - On mem_rvalid: owner rdata <= mem_rdata, owner rvalid pulses next cycle, go to IDLE.
- Latency:
  - gnt arrives 1 cycle after req.
  - mem_req rises 1 cycle after gnt.
  - Minimum write: 3 cycles req-to-rvalid with mem_ready already high.
  - Minimum read: 4 cycles when mem_rvalid follows accept by 1 cycle.
- Boundaries:
  - mem_rvalid outside WAIT is ignored.
  - mem_ready outside ISSUE is ignored.
  - A req dropped before gnt is not served.
  - A new request from the same port during its own transaction waits for IDLE.
  - Back-to-back contention alternates strictly: m0, m1, m0, ...
  - A single continuous requester is served every transaction.
  - Only one rvalid is ever asserted per cycle.

Optional Feature:
- ARB_TIMEOUT_EN defined:
  - A counter clears on WAIT entry and increments each WAIT cycle.
  - If it reaches TIMEOUT_CYCLES with no mem_rvalid: owner rdata <= 32'hDEAD_BEEF, owner rvalid pulses, err <= 1 (sticky until reset), go to IDLE.
  - A mem_rvalid arriving on the same cycle as the timeout takes priority and err is not set.
- ARB_TIMEOUT_EN undefined:
  - No counter; WAIT holds indefinitely; err = 0.

Decomposition:
- Package mem_bus_pkg holds:
  - arb_state_t enum {IDLE, ISSUE, WAIT}
  - MemWrite constants: WE_NONE = 2'b00, WE_BYTE = 2'b01, WE_HALF = 2'b10, WE_WORD = 2'b11
  - TIMEOUT_DATA = 32'hDEAD_BEEF
- One sub-module, rr_arbiter2: combinational 2-way round-robin pick from req[1:0] and rr_last.
- FSM and latches stay in the top module.

Test Plan:
- Solo m0 read:
  - Stimulus: m0_req, addr = 0x10, we = 00; mem_ready = 1; mem_rvalid one cycle after accept with rdata = 0xCAFEF00D.
  - Response: m0_gnt at cycle 1, mem_req at cycle 2, m0_rvalid = 1 with m0_rdata = 0xCAFEF00D at cycle 4.
- Contention:
  - Stimulus: m0 and m1 both request word writes continuously for 4 transactions.
  - Response: grants go m0, m1, m0, m1; each rvalid reaches the correct owner; m*_rdata unchanged.
- Memory backpressure:
  - Stimulus: mem_ready held 0 for 5 cycles during ISSUE.
  - Response: mem_req and mem_addr/mem_wdata/mem_we/mem_size stay stable; completion follows the first mem_ready.
- Reset in WAIT:
  - Stimulus: assert reset while in WAIT, then pulse mem_rvalid.
  - Response: no rvalid on either port; busy = 0; next contested arbitration grants m0.
- Stray inputs:
  - Stimulus: mem_rvalid pulse while IDLE; m1_req pulsed for 1 cycle while busy.
  - Response: both ignored; m1 is never granted.
- Timeout (ARB_TIMEOUT_EN, TIMEOUT_CYCLES = 8):
  - Stimulus: read with mem_rvalid never asserted.
  - Response: after 8 WAIT cycles, rvalid pulses with rdata = 0xDEADBEEF, err = 1 and stays 1.
